// File: rtl/riscv_fetch_align.sv
// Instruction fetch realignment buffer: turns word-aligned memory reads into
// a stream of complete 16/32-bit instructions, including ones that straddle
// a word boundary, and handles halfword-aligned PC redirects.
module riscv_fetch_align #(
  parameter logic [31:0] PC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction memory side
  output logic        if_req,
  output logic [31:0] if_adr,
  input  logic        if_ack,
  input  logic [31:0] if_rdt,
  // Redirect
  input  logic        jmp_vld,
  input  logic [31:0] jmp_adr,
  // Decoder side
  output logic        ins_vld,
  input  logic        ins_rdy,
  output logic [31:0] ins_pc,
  output logic [31:0] ins_dat,
  output logic        ins_cmp
);

  // Halfword FIFO; slot 0 always holds the halfword at ins_pc.
  logic [15:0] slot_q [4];
  logic [15:0] slot_d [4];
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fpc_q, fpc_d;
  logic        skip_q, skip_d;
  logic        pend_q, pend_d;

  logic        is32;
  logic [2:0]  n_in;
  logic [2:0]  n_out;
  logic [2:0]  base;
  logic [3:0]  fill;

  // Present the instruction at the head of the buffer and size this cycle's pop/push.
  always_comb begin
    is32    = (slot_q[0][1:0] == 2'b11);
    ins_vld = is32 ? (cnt_q >= 3'd2) : (cnt_q >= 3'd1);
    ins_cmp = !is32;
    ins_dat = is32 ? {slot_q[1], slot_q[0]} : {16'h0000, slot_q[0]};
    ins_pc  = pc_q;
    n_out   = (ins_vld && ins_rdy) ? (is32 ? 3'd2 : 3'd1) : 3'd0;
    n_in    = pend_q ? (skip_q ? 3'd1 : 3'd2) : 3'd0;
    // Only request when the response is guaranteed to fit after this cycle's traffic.
    fill    = {1'b0, cnt_q} + {1'b0, n_in} + 4'd2;
    if_req  = !rst && !jmp_vld && (fill <= (4'd4 + {1'b0, n_out}));
    if_adr  = fpc_q;
  end

  // Next-state: pop from the head, append the captured response, then let a redirect override.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q - n_out + n_in;
    pc_d   = pc_q + {28'h0, n_out, 1'b0};
    fpc_d  = (if_req && if_ack) ? fpc_q + 32'd4 : fpc_q;
    skip_d = pend_q ? 1'b0 : skip_q;
    pend_d = if_req && if_ack;
    base   = cnt_q - n_out;

    case (n_out)
      3'd1:    slot_d = '{slot_q[1], slot_q[2], slot_q[3], slot_q[3]};
      3'd2:    slot_d = '{slot_q[2], slot_q[3], slot_q[2], slot_q[3]};
      default: slot_d = slot_q;
    endcase

    if (pend_q) begin
      for (int i = 0; i < 4; i++) begin
        if (skip_q) begin
          if (3'(i) == base) slot_d[i] = if_rdt[31:16];
        end else begin
          if (3'(i) == base) slot_d[i] = if_rdt[15:0];
          else if (3'(i) == base + 3'd1) slot_d[i] = if_rdt[31:16];
        end
      end
    end

    // Redirect discards buffered and in-flight data; a same-cycle handshake is a no-op.
    if (jmp_vld) begin
      cnt_d  = 3'd0;
      pc_d   = jmp_adr & ~32'd1;
      fpc_d  = jmp_adr & ~32'd3;
      skip_d = jmp_adr[1];
      pend_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) slot_q[i] <= 16'h0000;
      cnt_q  <= 3'd0;
      pc_q   <= PC_RST & ~32'd1;
      fpc_q  <= PC_RST & ~32'd3;
      skip_q <= PC_RST[1];
      pend_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      fpc_q  <= fpc_d;
      skip_q <= skip_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_align.sv
// Directed bench for riscv_fetch_align with a halfword memory model and a
// randomized 16/32-bit stream checked against a bench-built golden list.
module tb_riscv_fetch_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_adr;
  logic        if_ack;
  logic [31:0] if_rdt;
  logic        jmp_vld;
  logic [31:0] jmp_adr;
  logic        ins_vld;
  logic        ins_rdy;
  logic [31:0] ins_pc;
  logic [31:0] ins_dat;
  logic        ins_cmp;

  riscv_fetch_align #(.PC_RST(32'h0000_0000)) dut (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_adr  (if_adr),
    .if_ack  (if_ack),
    .if_rdt  (if_rdt),
    .jmp_vld (jmp_vld),
    .jmp_adr (jmp_adr),
    .ins_vld (ins_vld),
    .ins_rdy (ins_rdy),
    .ins_pc  (ins_pc),
    .ins_dat (ins_dat),
    .ins_cmp (ins_cmp)
  );

  always #5 clk = ~clk;

  logic [15:0] hmem [256];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Values sampled at the negative edge of the cycle just completed
  logic        s_req, s_vld, s_rdy, s_cmp, s_hs;
  logic [31:0] s_adr, s_pc, s_dat;

  localparam int N = 40;
  logic [31:0] exp_pc  [N];
  logic [31:0] exp_dat [N];
  logic        exp_cmp [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, then return the memory response after the edge.
  task automatic tick();
    logic acc;
    int   a;
    @(negedge clk);
    s_req = if_req;
    s_adr = if_adr;
    s_vld = ins_vld;
    s_rdy = ins_rdy;
    s_pc  = ins_pc;
    s_dat = ins_dat;
    s_cmp = ins_cmp;
    s_hs  = ins_vld && ins_rdy && !jmp_vld;
    acc   = if_req && if_ack;
    a     = int'(if_adr[8:1]);
    @(posedge clk);
    #1;
    if_rdt = acc ? {hmem[(a + 1) % 256], hmem[a]} : 32'hDEAD_BEEF;
  endtask

  task automatic chk_ins(input string tag, input logic [31:0] pc, input logic [31:0] dat,
                         input logic cmp);
    chk({tag, "_vld"}, 32'(s_vld), 32'd1);
    chk({tag, "_pc"},  s_pc,  pc);
    chk({tag, "_dat"}, s_dat, dat);
    chk({tag, "_cmp"}, 32'(s_cmp), 32'(cmp));
  endtask

  task automatic chk_req(input string tag, input logic [31:0] adr);
    chk({tag, "_req"}, 32'(s_req), 32'd1);
    chk({tag, "_adr"}, s_adr, adr);
  endtask

  initial begin
    int          idx;
    int          hw;
    logic [31:0] pc;
    logic [15:0] lo, hi;
    logic        prev_stall;
    logic [31:0] prev_dat;

    for (int i = 0; i < 256; i++) hmem[i] = 16'h0001;
    // Four compressed ops at 0x0
    hmem[0] = 16'h0001; hmem[1] = 16'h4505; hmem[2] = 16'h8082; hmem[3] = 16'h0405;
    // C at 0x10, 32-bit addi at 0x12 straddling into word 0x14
    hmem[8] = 16'h0001; hmem[9] = 16'h0093; hmem[10] = 16'h00A0; hmem[11] = 16'h0001;
    // Word 0x100: lower half looks 32-bit and must be skipped, upper is compressed
    hmem[8'h80] = 16'h0013; hmem[8'h81] = 16'h4585;
    // 32-bit at 0x30, then two compressed
    hmem[8'h18] = 16'h0113; hmem[8'h19] = 16'h0010; hmem[8'h1A] = 16'h0505;
    hmem[8'h1B] = 16'h0609;

    rst = 1'b1; if_ack = 1'b1; ins_rdy = 1'b1; jmp_vld = 1'b0; jmp_adr = 32'h0;
    if_rdt = 32'h0;

    // Reset
    tick();
    tick();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_vld", 32'(s_vld), 32'd0);
    rst = 1'b0;

    // Four compressed ops from PC 0
    tick(); chk_req("c1", 32'h0); chk("c1_vld", 32'(s_vld), 32'd0);
    tick(); chk_req("c2", 32'h4); chk("c2_vld", 32'(s_vld), 32'd0);
    tick(); chk_ins("c3", 32'h0, 32'h0000_0001, 1'b1); chk("c3_req", 32'(s_req), 32'd0);
    tick(); chk_ins("c4", 32'h2, 32'h0000_4505, 1'b1); chk_req("c4", 32'h8);
    tick(); chk_ins("c5", 32'h4, 32'h0000_8082, 1'b1);
    tick(); chk_ins("c6", 32'h6, 32'h0000_0405, 1'b1);

    // Straddling 32-bit instruction
    jmp_vld = 1'b1; jmp_adr = 32'h10;
    tick(); chk("j_req", 32'(s_req), 32'd0);
    jmp_vld = 1'b0;
    tick(); chk_req("j1", 32'h10); chk("j1_vld", 32'(s_vld), 32'd0);
    tick(); chk_req("j2", 32'h14); chk("j2_vld", 32'(s_vld), 32'd0);
    tick(); chk_ins("j3", 32'h10, 32'h0000_0001, 1'b1);
    tick(); chk_ins("j4", 32'h12, 32'h00A0_0093, 1'b0);

    // Redirect to odd halfword while a response is pending
    jmp_vld = 1'b1; jmp_adr = 32'h20;
    tick();
    jmp_vld = 1'b0;
    tick(); chk_req("k1", 32'h20);
    jmp_vld = 1'b1; jmp_adr = 32'h103;
    tick(); chk("k2_req", 32'(s_req), 32'd0);
    jmp_vld = 1'b0;
    tick(); chk_req("k3", 32'h100);
    tick(); chk("k4_vld", 32'(s_vld), 32'd0); chk_req("k4", 32'h104);
    tick(); chk_ins("k5", 32'h102, 32'h0000_4585, 1'b1);

    // Consumer stall with a full buffer
    ins_rdy = 1'b0;
    jmp_vld = 1'b1; jmp_adr = 32'h30;
    tick();
    jmp_vld = 1'b0;
    tick(); chk_req("s1", 32'h30);
    tick(); chk_req("s2", 32'h34);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_ins("stall", 32'h30, 32'h0010_0113, 1'b0);
      chk("stall_req", 32'(s_req), 32'd0);
    end
    ins_rdy = 1'b1;
    tick(); chk_ins("d0", 32'h30, 32'h0010_0113, 1'b0); chk_req("d0", 32'h38);
    tick(); chk_ins("d1", 32'h34, 32'h0000_0505, 1'b1);
    tick(); chk_ins("d2", 32'h36, 32'h0000_0609, 1'b1);

    // Reset mid-operation with buffered halfwords and a response in flight
    jmp_vld = 1'b1; jmp_adr = 32'h10;
    tick();
    jmp_vld = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick(); chk("r_req", 32'(s_req), 32'd0);
    rst = 1'b0;
    tick(); chk("r1_vld", 32'(s_vld), 32'd0); chk("r1_pc", s_pc, 32'h0); chk_req("r1", 32'h0);
    tick(); chk("r2_vld", 32'(s_vld), 32'd0);
    tick(); chk_ins("r3", 32'h0, 32'h0000_0001, 1'b1);

    // Random 16/32-bit stream from 0x82 with random ack and ready
    pc = 32'h82;
    hw = 32'h82 / 2;
    for (int i = 0; i < N; i++) begin
      exp_pc[i] = pc;
      if ($urandom_range(0, 1) == 1) begin
        lo       = 16'($urandom);
        lo[1:0]  = 2'($urandom_range(0, 2));
        hmem[hw] = lo;
        hw       = hw + 1;
        exp_dat[i] = {16'h0000, lo};
        exp_cmp[i] = 1'b1;
        pc = pc + 32'd2;
      end else begin
        lo       = 16'($urandom);
        lo[1:0]  = 2'b11;
        hi       = 16'($urandom);
        hmem[hw] = lo;
        hmem[hw + 1] = hi;
        hw       = hw + 2;
        exp_dat[i] = {hi, lo};
        exp_cmp[i] = 1'b0;
        pc = pc + 32'd4;
      end
    end

    jmp_vld = 1'b1; jmp_adr = 32'h82;
    tick();
    jmp_vld = 1'b0;
    idx = 0;
    prev_stall = 1'b0;
    prev_dat = 32'h0;
    for (int cyc = 0; cyc < 3000 && idx < N; cyc++) begin
      if_ack  = ($urandom_range(0, 1) == 1);
      ins_rdy = ($urandom_range(0, 3) != 0);
      tick();
      if (prev_stall) begin
        chk("stable_vld", 32'(s_vld), 32'd1);
        chk("stable_dat", s_dat, prev_dat);
      end
      prev_stall = s_vld && !s_rdy;
      prev_dat   = s_dat;
      if (s_hs) begin
        chk("rnd_pc",  s_pc,  exp_pc[idx]);
        chk("rnd_dat", s_dat, exp_dat[idx]);
        chk("rnd_cmp", 32'(s_cmp), 32'(exp_cmp[idx]));
        idx++;
      end
    end
    chk("rnd_count", 32'(idx), 32'(N));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
